pipe_tx_data: RTL and testbench

MAC-side PIPE transmit data path, the counterpart to the PIPE receive data block. It accepts symbols from the MAC framing logic through a valid/ready handshake and registers them onto the PIPE Tx interface. For 8b/10b (GEN1) it forwards data and K flags. For 128b/130b (GEN5) it tracks symbol and block boundaries, drives TxStartBlock and TxSyncHeader, and inserts the periodic TxDataValid stall cycle that absorbs the sync-header overhead.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_tx_data_if.sv | 32 +++
 rtl/pipe_tx_block_tracker.sv | 100 ++++++++++
 rtl/pipe_tx_data.sv | 83 ++++++++
 tb/tb_pipe_tx_data.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared GEN encodings, tx state enum and width helpers for the PIPE tx path
package pipe_pkg;

  localparam logic [2:0] GEN_1 = 3'd1;
  localparam logic [2:0] GEN_5 = 3'd5;

  localparam int BLOCK_BITS = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLOCK = 2'd1,
    ST_STALL = 2'd2
  } tx_state_e;

  // symbols per 128b/130b block
  function automatic int calc_n(input int width);
    return BLOCK_BITS / width;
  endfunction

  // blocks between TxDataValid stall cycles
  function automatic int calc_s(input int width);
    return width / 2;
  endfunction

  function automatic logic [31:0] width_mask(input logic [5:0] width);
    if (width >= 6'd32) return 32'hFFFF_FFFF;
    return (32'h1 << width) - 32'h1;
  endfunction

  // one K bit per byte; a width of 32 wraps the shift to 0 and yields 4'hF
  function automatic logic [3:0] k_mask(input logic [5:0] width);
    return (4'h1 << width[5:3]) - 4'h1;
  endfunction

endpackage

// File: rtl/pipe_tx_data_if.sv
// rtl/pipe_tx_data_if.sv - MAC-side handshake and PIPE Tx signal bundle
interface pipe_tx_data_if;

  logic [2:0]  GEN;
  logic [31:0] MACData;
  logic [3:0]  MACDataK;
  logic        MACDataValid;
  logic [1:0]  MACSyncHeader;
  logic        MACElectricalIdle;
  logic        MACReady;
  logic        BlockUnderrun;
  logic [31:0] TxData;
  logic [3:0]  TxDataK;
  logic        TxDataValid;
  logic        TxStartBlock;
  logic [1:0]  TxSyncHeader;
  logic        TxElecIdle;
  logic [5:0]  PIPEWIDTH;

  modport master (
    output GEN, MACData, MACDataK, MACDataValid, MACSyncHeader, MACElectricalIdle,
    input  MACReady, BlockUnderrun, TxData, TxDataK, TxDataValid, TxStartBlock,
           TxSyncHeader, TxElecIdle, PIPEWIDTH
  );

  modport slave (
    input  GEN, MACData, MACDataK, MACDataValid, MACSyncHeader, MACElectricalIdle,
    output MACReady, BlockUnderrun, TxData, TxDataK, TxDataValid, TxStartBlock,
           TxSyncHeader, TxElecIdle, PIPEWIDTH
  );

endinterface

// File: rtl/pipe_tx_block_tracker.sv
// rtl/pipe_tx_block_tracker.sv - 128b/130b symbol/block counting, stall and underrun generation
module pipe_tx_block_tracker
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      gen5,
  input  logic      accept,
  input  logic      data_valid,
  input  logic      elec_idle,
  input  logic      abort,
  output tx_state_e state,
  output logic      start_of_block,
  output logic      stall,
  output logic      underrun
);

  localparam int N = calc_n(WIDTH);
  localparam int S = calc_s(WIDTH);

  tx_state_e  state_q, state_d;
  logic [4:0] sym_q, sym_d;
  logic [4:0] blk_q, blk_d;
  logic       close;
  logic       clear;
  logic       bubble;
  logic       bubble_q;
  logic       underrun_q;

  assign clear          = !gen5 || elec_idle || abort;
  assign start_of_block = !clear && (state_q == ST_IDLE);
  assign bubble         = !clear && (state_q == ST_BLOCK) && !data_valid;

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    blk_d   = blk_q;
    close   = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      sym_d   = '0;
      blk_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (N == 1) begin
              close = 1'b1;
            end else begin
              sym_d   = 5'd1;
              state_d = ST_BLOCK;
            end
          end
        end
        ST_BLOCK: begin
          if (accept) begin
            if (sym_q == 5'(N - 1)) close = 1'b1;
            else                    sym_d = sym_q + 5'd1;
          end
        end
        ST_STALL: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
      if (close) begin
        sym_d = '0;
        if (blk_q == 5'(S - 1)) begin
          blk_d   = '0;
          state_d = ST_STALL;
        end else begin
          blk_d   = blk_q + 5'd1;
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      sym_q      <= '0;
      blk_q      <= '0;
      bubble_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_q      <= sym_d;
      blk_q      <= blk_d;
      bubble_q   <= bubble;
      // a multi-cycle bubble reports once, on its first cycle
      underrun_q <= bubble && !bubble_q;
    end
  end

  assign state    = state_q;
  assign stall    = (state_q == ST_STALL);
  assign underrun = underrun_q;

endmodule

// File: rtl/pipe_tx_data.sv
// rtl/pipe_tx_data.sv - MAC-side PIPE transmit data path for GEN1 8b/10b and GEN5 128b/130b
module pipe_tx_data
  import pipe_pkg::*;
#(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input logic          clk,
  input logic          reset,
  pipe_tx_data_if.slave bus
);

  logic        gen1;
  logic        gen5;
  logic        gen_ok;
  logic [2:0]  gen_q;
  logic        abort;
  logic        accept;
  logic [5:0]  active_width;
  logic [31:0] data_mask;
  logic [3:0]  kflag_mask;
  tx_state_e   state;
  logic        start_of_block;
  logic        stall;
  logic        underrun;

  assign gen1   = (bus.GEN == GEN_1);
  assign gen5   = (bus.GEN == GEN_5);
  assign gen_ok = gen1 || gen5;

  // a GEN change mid-block also withholds MACReady so the abort cycle drops no word
  assign abort = (bus.GEN != gen_q) && (state != ST_IDLE);

  assign bus.MACReady = reset && !stall && !bus.MACElectricalIdle && gen_ok && !abort;
  assign accept       = bus.MACDataValid && bus.MACReady;

  assign active_width = gen1 ? 6'(GEN1_PIPEWIDTH) : (gen5 ? 6'(GEN5_PIPEWIDTH) : 6'd0);
  assign data_mask    = width_mask(active_width);
  assign kflag_mask   = gen1 ? k_mask(6'(GEN1_PIPEWIDTH)) : 4'h0;
  assign bus.PIPEWIDTH = active_width;

  pipe_tx_block_tracker #(
    .WIDTH(GEN5_PIPEWIDTH)
  ) u_tracker (
    .clk           (clk),
    .reset         (reset),
    .gen5          (gen5),
    .accept        (accept),
    .data_valid    (bus.MACDataValid),
    .elec_idle     (bus.MACElectricalIdle),
    .abort         (abort),
    .state         (state),
    .start_of_block(start_of_block),
    .stall         (stall),
    .underrun      (underrun)
  );

  assign bus.BlockUnderrun = underrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.TxData       <= '0;
      bus.TxDataK      <= '0;
      bus.TxDataValid  <= 1'b0;
      bus.TxStartBlock <= 1'b0;
      bus.TxSyncHeader <= '0;
      bus.TxElecIdle   <= 1'b1;
      gen_q            <= '0;
    end else begin
      bus.TxDataValid  <= accept;
      bus.TxStartBlock <= accept && start_of_block;
      bus.TxSyncHeader <= (accept && start_of_block) ? bus.MACSyncHeader : 2'b00;
      bus.TxElecIdle   <= bus.MACElectricalIdle;
      gen_q            <= bus.GEN;
      // data and K hold their last value through stalls and bubbles
      if (accept) begin
        bus.TxData  <= bus.MACData & data_mask;
        bus.TxDataK <= bus.MACDataK & kflag_mask;
      end
    end
  end

endmodule

// File: tb/tb_pipe_tx_data.sv
// tb/tb_pipe_tx_data.sv - directed self-checking bench for pipe_tx_data
module tb_pipe_tx_data;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipe_tx_data_if bus ();

  pipe_tx_data #(
    .GEN1_PIPEWIDTH(8),
    .GEN5_PIPEWIDTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.GEN = 3'd1;
    bus.MACData = '0;
    bus.MACDataK = '0;
    bus.MACDataValid = 1'b0;
    bus.MACSyncHeader = 2'b00;
    bus.MACElectricalIdle = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_valid", 32'(bus.TxDataValid), 32'd0);
    chk("rst_eidle", 32'(bus.TxElecIdle), 32'd1);
    chk("rst_ready", 32'(bus.MACReady), 32'd0);
    chk("rst_data", bus.TxData, 32'h0);
    chk("rst_start", 32'(bus.TxStartBlock), 32'd0);
    reset = 1'b1;

    // GEN1 passthrough with width masking of data and K
    bus.MACData = 32'hFFFF_FFBC;
    bus.MACDataK = 4'hF;
    bus.MACDataValid = 1'b1;
    #1;
    chk("g1_ready", 32'(bus.MACReady), 32'd1);
    chk("g1_width", 32'(bus.PIPEWIDTH), 32'd8);
    tick();
    chk("g1_data0", bus.TxData, 32'hBC);
    chk("g1_k0", 32'(bus.TxDataK), 32'h1);
    chk("g1_valid0", 32'(bus.TxDataValid), 32'd1);
    chk("g1_start0", 32'(bus.TxStartBlock), 32'd0);
    chk("g1_eidle", 32'(bus.TxElecIdle), 32'd0);
    bus.MACData = 32'h0000_124A;
    bus.MACDataK = 4'h0;
    tick();
    chk("g1_data1", bus.TxData, 32'h4A);
    chk("g1_k1", 32'(bus.TxDataK), 32'h0);
    chk("g1_start1", 32'(bus.TxStartBlock), 32'd0);
    chk("g1_ready1", 32'(bus.MACReady), 32'd1);
    bus.MACDataValid = 1'b0;
    tick();
    chk("g1_idle_valid", 32'(bus.TxDataValid), 32'd0);

    // GEN5 continuous: four blocks of 16 symbols, then one stall cycle
    bus.GEN = 3'd5;
    bus.MACSyncHeader = 2'b01;
    bus.MACDataValid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.MACData = 32'h0000_0300 + 32'(i);
      tick();
      chk("g5_valid", 32'(bus.TxDataValid), 32'd1);
      chk("g5_data", bus.TxData, 32'(i));
      chk("g5_start", 32'(bus.TxStartBlock), (i % 16 == 0) ? 32'd1 : 32'd0);
      chk("g5_sync", 32'(bus.TxSyncHeader), (i % 16 == 0) ? 32'd1 : 32'd0);
      chk("g5_k", 32'(bus.TxDataK), 32'h0);
    end
    chk("g5_stall_ready", 32'(bus.MACReady), 32'd0);
    bus.MACData = 32'd64;
    tick();
    chk("g5_stall_valid", 32'(bus.TxDataValid), 32'd0);
    chk("g5_stall_hold", bus.TxData, 32'd63);
    chk("g5_stall_start", 32'(bus.TxStartBlock), 32'd0);
    chk("g5_post_ready", 32'(bus.MACReady), 32'd1);
    tick();
    chk("g5_w64_start", 32'(bus.TxStartBlock), 32'd1);
    chk("g5_w64_data", bus.TxData, 32'd64);

    // mid-block bubble at symbol 5
    for (int j = 1; j < 5; j++) begin
      bus.MACData = 32'd64 + 32'(j);
      tick();
      chk("bub_pre_start", 32'(bus.TxStartBlock), 32'd0);
    end
    bus.MACDataValid = 1'b0;
    tick();
    chk("bub_valid0", 32'(bus.TxDataValid), 32'd0);
    chk("bub_pulse", 32'(bus.BlockUnderrun), 32'd1);
    tick();
    chk("bub_valid1", 32'(bus.TxDataValid), 32'd0);
    chk("bub_pulse_end", 32'(bus.BlockUnderrun), 32'd0);
    chk("bub_hold", bus.TxData, 32'd68);
    bus.MACDataValid = 1'b1;
    for (int j = 5; j < 16; j++) begin
      bus.MACData = 32'd64 + 32'(j);
      tick();
      chk("bub_resume_valid", 32'(bus.TxDataValid), 32'd1);
      chk("bub_resume_start", 32'(bus.TxStartBlock), 32'd0);
      chk("bub_resume_data", bus.TxData, 32'd64 + 32'(j));
    end
    bus.MACData = 32'h0000_00A0;
    tick();
    chk("bub_next_start", 32'(bus.TxStartBlock), 32'd1);

    // electrical idle at symbol 9 restarts block counting
    for (int j = 1; j < 9; j++) begin
      bus.MACData = 32'h0000_00A0 + 32'(j);
      tick();
    end
    bus.MACElectricalIdle = 1'b1;
    #1;
    chk("ei_ready", 32'(bus.MACReady), 32'd0);
    tick();
    chk("ei_txeidle", 32'(bus.TxElecIdle), 32'd1);
    chk("ei_valid", 32'(bus.TxDataValid), 32'd0);
    bus.MACElectricalIdle = 1'b0;
    bus.MACData = 32'h0000_0000;
    tick();
    chk("ei_restart_start", 32'(bus.TxStartBlock), 32'd1);
    chk("ei_restart_eidle", 32'(bus.TxElecIdle), 32'd0);
    for (int k = 1; k < 64; k++) begin
      bus.MACData = 32'(k);
      tick();
      chk("ei_blk_start", 32'(bus.TxStartBlock), (k % 16 == 0) ? 32'd1 : 32'd0);
    end
    chk("ei_stall_ready", 32'(bus.MACReady), 32'd0);
    tick();
    chk("ei_stall_valid", 32'(bus.TxDataValid), 32'd0);

    // GEN 5 -> 1 switch at symbol 4 of a block
    for (int j = 0; j < 4; j++) begin
      bus.MACData = 32'h0000_0010 + 32'(j);
      tick();
    end
    bus.MACDataValid = 1'b0;
    bus.GEN = 3'd1;
    #1;
    chk("sw_abort_ready", 32'(bus.MACReady), 32'd0);
    tick();
    chk("sw_abort_valid", 32'(bus.TxDataValid), 32'd0);
    chk("sw_abort_underrun", 32'(bus.BlockUnderrun), 32'd0);
    bus.MACDataValid = 1'b1;
    bus.MACData = 32'h0000_01C5;
    bus.MACDataK = 4'h1;
    #1;
    chk("sw_g1_ready", 32'(bus.MACReady), 32'd1);
    tick();
    chk("sw_g1_data", bus.TxData, 32'hC5);
    chk("sw_g1_k", 32'(bus.TxDataK), 32'h1);
    chk("sw_g1_start", 32'(bus.TxStartBlock), 32'd0);
    bus.GEN = 3'd3;
    #1;
    chk("g3_ready", 32'(bus.MACReady), 32'd0);
    chk("g3_width", 32'(bus.PIPEWIDTH), 32'd0);
    tick();
    chk("g3_valid", 32'(bus.TxDataValid), 32'd0);

    // reset asserted during a stall cycle
    bus.GEN = 3'd5;
    bus.MACDataK = 4'h0;
    for (int i = 0; i < 64; i++) begin
      bus.MACData = 32'(i);
      tick();
    end
    chk("rs_in_stall", 32'(bus.MACReady), 32'd0);
    reset = 1'b0;
    #1;
    chk("rs_data", bus.TxData, 32'h0);
    chk("rs_eidle", 32'(bus.TxElecIdle), 32'd1);
    chk("rs_valid", 32'(bus.TxDataValid), 32'd0);
    chk("rs_ready", 32'(bus.MACReady), 32'd0);
    chk("rs_sync", 32'(bus.TxSyncHeader), 32'd0);
    reset = 1'b1;
    bus.MACData = 32'h0000_005A;
    #1;
    chk("rs_rel_ready", 32'(bus.MACReady), 32'd1);
    tick();
    chk("rs_first_start", 32'(bus.TxStartBlock), 32'd1);
    chk("rs_first_sync", 32'(bus.TxSyncHeader), 32'd1);
    chk("rs_first_data", bus.TxData, 32'h5A);
    chk("rs_first_eidle", 32'(bus.TxElecIdle), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
